reg_tag_file: RTL and testbench
===============================

REG_TAG_FILE -- requirements
Module: reg_tag_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter REG_NUM, default 32, architectural register count; REG_W = clog2(REG_NUM).
REQ-003 SHALL have parameter TAG_W, default 4, ROB tag width.
REQ-004 SHALL have parameter RD_PORTS, default 2, number of source read ports (legal 1..4).
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port flush  in  1  mispredict/exception flush; discards all pending renames.
REQ-008 SHALL have ports alloc_ce / alloc_rd / alloc_tag  in  1 / REG_W / TAG_W  rename destination register to a ROB tag.
REQ-009 SHALL have ports wb_ce / wr / w_tag / wd  in  1 / REG_W / TAG_W / XLEN  in-order commit write.
REQ-010 SHALL have ports ce / rs  in  RD_PORTS / RD_PORTS*REG_W  per-port read enable and source register.
REQ-011 SHALL have ports src / src_busy / tag  out  RD_PORTS*XLEN / RD_PORTS / RD_PORTS*TAG_W  per-port value, pending flag, producing tag.
REQ-012 SHALL have port busy_cnt  out  REG_W+1  count of registers currently renamed.

Function
REQ-013 State SHALL be val[REG_NUM], busy[REG_NUM], tag[REG_NUM], busy_cnt; register 0 SHALL read val 0, busy 0, tag 0 always and SHALL never become busy.
REQ-014 Commit (wb_ce=1, wr!=0): val[wr] <= wd unconditionally; busy[wr] <= 0 only if busy[wr] and tag[wr]==w_tag (a younger rename survives).
REQ-015 Allocate (alloc_ce=1, alloc_rd!=0, flush=0): busy[alloc_rd] <= 1, tag[alloc_rd] <= alloc_tag.
REQ-016 Same-cycle commit and allocate to same register: val updated per REQ-014; busy stays 1, tag = alloc_tag (allocate wins).
REQ-017 Flush: all busy <= 0 next edge; alloc ignored that cycle; commit value write in same cycle still performed.
REQ-018 Reads SHALL be combinational, zero latency, each port independent.
REQ-019 Port p with ce[p]=0: src 0, src_busy 0, tag 0.
REQ-020 Port p, rs!=0, busy[rs]=1, wb_ce=1, wr==rs, w_tag==tag[rs]: bypass -> src=wd, src_busy 0, tag 0.
REQ-021 Port p, busy[rs]=1 otherwise: src=val[rs], src_busy 1, tag=tag[rs].
REQ-022 Port p, busy[rs]=0: src = (wb_ce and wr==rs) ? wd : val[rs], src_busy 0, tag 0.
REQ-023 Reads SHALL NOT observe a same-cycle allocate (sources renamed before destination, so "add r1,r1,r2" reads the old r1 mapping).
REQ-024 busy_cnt SHALL equal the number of set busy bits after each edge: +1 on allocate to a non-busy register, -1 on a matching commit clear, net 0 when both hit one register, 0 after flush; never exceeds REG_NUM-1.
REQ-025 Re-allocating an already busy register SHALL overwrite its tag without changing busy_cnt.

Reset
REQ-026 On rst=1 at a rising edge: all val <= 0, busy <= 0, tag <= 0, busy_cnt <= 0; rst has priority over flush, commit and allocate.
REQ-027 Outputs after reset: src 0, src_busy 0, tag 0 on every port, busy_cnt 0.
REQ-028 Reset asserted mid-operation SHALL discard all pending renames in one cycle; no partial state retained.

Verification
REQ-029 Reset, then ce=2'b11, rs={5,0} -> src 0/0, src_busy 0/0, busy_cnt 0.
REQ-030 Alloc r5 tag 3; next cycle read r5 -> src_busy 1, tag 3, busy_cnt 1; commit wr=5 w_tag=3 wd=0xDEADBEEF same cycle -> bypass src 0xDEADBEEF, busy 0; next cycle busy_cnt 0.
REQ-031 Alloc r7 tag 2, then alloc r7 tag 9; commit wr=7 w_tag=2 wd=0x11 -> val[7]=0x11, r7 still busy tag 9, busy_cnt 1.
REQ-032 Same cycle alloc r4 tag 6 and read r4 (r4 idle, val 0x55) -> src 0x55, src_busy 0; next cycle read -> busy 1, tag 6.
REQ-033 Alloc r1,r2,r3 (tags 1,2,3), flush with commit wr=2 wd=0x77 -> busy_cnt 0, all busy 0, val[2]=0x77.
REQ-034 Alloc r0 tag 5 and commit wr=0 wd=0xFF -> r0 reads 0, busy_cnt unchanged; repeat with RD_PORTS=4 on all ports.

Source files
------------

// File: rtl/reg_tag_file.sv
// rtl/reg_tag_file.sv - architectural register file with rename tags and commit bypass
module reg_tag_file #(
   parameter int XLEN     = 32,
   parameter int REG_NUM  = 32,
   parameter int TAG_W    = 4,
   parameter int RD_PORTS = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic                                alloc_ce,
   input  logic [$clog2(REG_NUM)-1:0]          alloc_rd,
   input  logic [TAG_W-1:0]                    alloc_tag,
   input  logic                                wb_ce,
   input  logic [$clog2(REG_NUM)-1:0]          wr,
   input  logic [TAG_W-1:0]                    w_tag,
   input  logic [XLEN-1:0]                     wd,
   input  logic [RD_PORTS-1:0]                 ce,
   input  logic [RD_PORTS*$clog2(REG_NUM)-1:0] rs,
   output logic [RD_PORTS*XLEN-1:0]            src,
   output logic [RD_PORTS-1:0]                 src_busy,
   output logic [RD_PORTS*TAG_W-1:0]           tag,
   output logic [$clog2(REG_NUM):0]            busy_cnt
);

   localparam int REG_W = $clog2(REG_NUM);
   localparam logic [REG_W:0] CNT_ONE = {{REG_W{1'b0}}, 1'b1};

   logic [XLEN-1:0]    val_q [REG_NUM];
   logic [XLEN-1:0]    val_d [REG_NUM];
   logic [TAG_W-1:0]   tag_q [REG_NUM];
   logic [TAG_W-1:0]   tag_d [REG_NUM];
   logic [REG_NUM-1:0] busy_q;
   logic [REG_NUM-1:0] busy_d;
   logic [REG_W:0]     cnt_q;
   logic [REG_W:0]     cnt_d;

   logic commit_wr;
   logic commit_clr;
   logic alloc_go;
   logic alloc_new;
   logic clr_dec;

   // Register 0 is hardwired: it is never written, renamed or counted.
   assign commit_wr  = wb_ce && (wr != '0);
   assign commit_clr = commit_wr && busy_q[wr] && (tag_q[wr] == w_tag);
   assign alloc_go   = alloc_ce && (alloc_rd != '0) && !flush;
   assign alloc_new  = alloc_go && !busy_q[alloc_rd];
   // A clear that the same-cycle allocate re-sets on the same register is not a release.
   assign clr_dec    = commit_clr && !(alloc_go && (alloc_rd == wr));

   // Next-state: commit value, tag-matched release, then allocate (allocate wins).
   always_comb begin
      val_d  = val_q;
      tag_d  = tag_q;
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (commit_wr) begin
         val_d[wr] = wd;
      end
      if (flush) begin
         busy_d = '0;
         cnt_d  = '0;
      end else begin
         if (commit_clr) begin
            busy_d[wr] = 1'b0;
         end
         if (alloc_go) begin
            busy_d[alloc_rd] = 1'b1;
            tag_d[alloc_rd]  = alloc_tag;
         end
         if (alloc_new && !clr_dec) begin
            cnt_d = cnt_q + CNT_ONE;
         end else if (clr_dec && !alloc_new) begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end
   end

   // State registers; reset wipes values and every pending rename at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            val_q[i] <= '0;
            tag_q[i] <= '0;
         end
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         val_q  <= val_d;
         tag_q  <= tag_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_cnt = cnt_q;

   // Read ports see only registered state plus the current commit, never this cycle's allocate.
   for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
      logic [REG_W-1:0] rd;
      logic             wb_hit;
      logic [XLEN-1:0]  src_p;
      logic             busy_p;
      logic [TAG_W-1:0] tag_p;

      assign rd     = rs[p*REG_W +: REG_W];
      assign wb_hit = wb_ce && (wr == rd);

      // Resolve one source: pending rename, bypassed commit, or architectural value.
      always_comb begin
         src_p  = '0;
         busy_p = 1'b0;
         tag_p  = '0;
         if (ce[p] && (rd != '0)) begin
            if (busy_q[rd]) begin
               if (wb_hit && (w_tag == tag_q[rd])) begin
                  src_p = wd;
               end else begin
                  src_p  = val_q[rd];
                  busy_p = 1'b1;
                  tag_p  = tag_q[rd];
               end
            end else if (wb_hit) begin
               src_p = wd;
            end else begin
               src_p = val_q[rd];
            end
         end
      end

      assign src[p*XLEN +: XLEN]   = src_p;
      assign src_busy[p]           = busy_p;
      assign tag[p*TAG_W +: TAG_W] = tag_p;
   end

endmodule

// File: tb/tb_reg_tag_file.sv
// tb/tb_reg_tag_file.sv - self-checking bench for reg_tag_file with a rename-table model
module tb_reg_tag_file;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        alloc_ce;
   logic [4:0]  alloc_rd;
   logic [3:0]  alloc_tag;
   logic        wb_ce;
   logic [4:0]  wr;
   logic [3:0]  w_tag;
   logic [31:0] wd;

   logic [1:0]   ce2;
   logic [9:0]   rs2;
   logic [63:0]  src2;
   logic [1:0]   sb2;
   logic [7:0]   tag2;
   logic [5:0]   cnt2;

   logic [3:0]   ce4;
   logic [19:0]  rs4;
   logic [127:0] src4;
   logic [3:0]   sb4;
   logic [15:0]  tag4;
   logic [5:0]   cnt4;

   int compared;
   int mismatched;

   logic [31:0] m_val  [32];
   logic [3:0]  m_tag  [32];
   bit          m_busy [32];

   reg_tag_file #(.XLEN(32), .REG_NUM(32), .TAG_W(4), .RD_PORTS(2)) u_dut2 (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_ce(alloc_ce), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
      .wb_ce(wb_ce), .wr(wr), .w_tag(w_tag), .wd(wd),
      .ce(ce2), .rs(rs2), .src(src2), .src_busy(sb2), .tag(tag2), .busy_cnt(cnt2)
   );

   reg_tag_file #(.XLEN(32), .REG_NUM(32), .TAG_W(4), .RD_PORTS(4)) u_dut4 (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_ce(alloc_ce), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
      .wb_ce(wb_ce), .wr(wr), .w_tag(w_tag), .wd(wd),
      .ce(ce4), .rs(rs4), .src(src4), .src_busy(sb4), .tag(tag4), .busy_cnt(cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic int pending_count();
      int n = 0;
      for (int i = 0; i < 32; i++) n += m_busy[i] ? 1 : 0;
      return n;
   endfunction

   // What a reader must see for (ce, rs) given the table and this cycle's commit.
   task automatic exp_read(input logic c, input logic [4:0] r,
                           output logic [31:0] s, output logic b, output logic [3:0] t);
      s = '0; b = 1'b0; t = '0;
      if (c && r != 5'd0) begin
         if (m_busy[r] && !(wb_ce && wr == r && w_tag == m_tag[r])) begin
            s = m_val[r]; b = 1'b1; t = m_tag[r];
         end else if (wb_ce && wr == r) begin
            s = wd;
         end else begin
            s = m_val[r];
         end
      end
   endtask

   task automatic check_outputs();
      logic [31:0] s;
      logic        b;
      logic [3:0]  t;
      for (int p = 0; p < 2; p++) begin
         exp_read(ce2[p], rs2[p*5 +: 5], s, b, t);
         check($sformatf("p2.src[%0d]", p),  {32'd0, src2[p*32 +: 32]}, {32'd0, s});
         check($sformatf("p2.busy[%0d]", p), {63'd0, sb2[p]}, {63'd0, b});
         check($sformatf("p2.tag[%0d]", p),  {60'd0, tag2[p*4 +: 4]}, {60'd0, t});
      end
      for (int p = 0; p < 4; p++) begin
         exp_read(ce4[p], rs4[p*5 +: 5], s, b, t);
         check($sformatf("p4.src[%0d]", p),  {32'd0, src4[p*32 +: 32]}, {32'd0, s});
         check($sformatf("p4.busy[%0d]", p), {63'd0, sb4[p]}, {63'd0, b});
         check($sformatf("p4.tag[%0d]", p),  {60'd0, tag4[p*4 +: 4]}, {60'd0, t});
      end
      check("p2.busy_cnt", {58'd0, cnt2}, 64'(pending_count()));
      check("p4.busy_cnt", {58'd0, cnt4}, 64'(pending_count()));
   endtask

   // Architectural effect of one clock edge on the rename table.
   task automatic model_edge();
      bit release_hit;
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_tag[i] = '0; m_busy[i] = 1'b0;
         end
      end else begin
         release_hit = 1'b0;
         if (wb_ce && wr != 5'd0) begin
            m_val[wr]   = wd;
            release_hit = m_busy[wr] && (m_tag[wr] == w_tag);
         end
         if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         end else begin
            if (release_hit) m_busy[wr] = 1'b0;
            if (alloc_ce && alloc_rd != 5'd0) begin
               m_busy[alloc_rd] = 1'b1;
               m_tag[alloc_rd]  = alloc_tag;
            end
         end
      end
   endtask

   task automatic tick(input bit do_check);
      #1;
      if (do_check) check_outputs();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 1'b0; flush = 1'b0;
      alloc_ce = 1'b0; alloc_rd = '0; alloc_tag = '0;
      wb_ce = 1'b0; wr = '0; w_tag = '0; wd = '0;
      ce2 = '0; rs2 = '0; ce4 = '0; rs4 = '0;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      for (int i = 0; i < 32; i++) begin
         m_val[i] = '0; m_tag[i] = '0; m_busy[i] = 1'b0;
      end

      idle();
      rst = 1'b1;
      tick(0);
      tick(0);
      idle();

      // Reset state, reading r5 and r0
      ce2 = 2'b11; rs2 = {5'd5, 5'd0};
      ce4 = 4'b1111; rs4 = {5'd5, 5'd0, 5'd31, 5'd1};
      #1;
      check("rst.src", {32'd0, src2[63:32]}, 64'd0);
      check("rst.busy", {62'd0, sb2}, 64'd0);
      check("rst.cnt", {58'd0, cnt2}, 64'd0);
      check("rst.src4", src4[63:0], 64'd0);
      tick(1);

      // Allocate r5 tag 3, then commit it with bypass
      idle(); alloc_ce = 1'b1; alloc_rd = 5'd5; alloc_tag = 4'd3;
      tick(1);
      idle(); ce2 = 2'b01; rs2 = {5'd0, 5'd5};
      #1;
      check("alloc.busy", {63'd0, sb2[0]}, 64'd1);
      check("alloc.tag", {60'd0, tag2[3:0]}, 64'd3);
      check("alloc.cnt", {58'd0, cnt2}, 64'd1);
      wb_ce = 1'b1; wr = 5'd5; w_tag = 4'd3; wd = 32'hDEADBEEF;
      #1;
      check("bypass.src", {32'd0, src2[31:0]}, 64'hDEADBEEF);
      check("bypass.busy", {63'd0, sb2[0]}, 64'd0);
      tick(1);
      idle();
      #1;
      check("commit.cnt", {58'd0, cnt2}, 64'd0);
      tick(1);

      // Younger rename survives an older commit
      idle(); alloc_ce = 1'b1; alloc_rd = 5'd7; alloc_tag = 4'd2;
      tick(1);
      alloc_tag = 4'd9;
      tick(1);
      idle(); wb_ce = 1'b1; wr = 5'd7; w_tag = 4'd2; wd = 32'h11;
      tick(1);
      idle(); ce2 = 2'b10; rs2 = {5'd7, 5'd0};
      #1;
      check("young.src", {32'd0, src2[63:32]}, 64'h11);
      check("young.busy", {63'd0, sb2[1]}, 64'd1);
      check("young.tag", {60'd0, tag2[7:4]}, 64'd9);
      check("young.cnt", {58'd0, cnt2}, 64'd1);
      tick(1);

      // Same-cycle allocate is invisible to the reader
      idle(); wb_ce = 1'b1; wr = 5'd4; wd = 32'h55;
      tick(1);
      idle(); alloc_ce = 1'b1; alloc_rd = 5'd4; alloc_tag = 4'd6;
      ce2 = 2'b01; rs2 = {5'd0, 5'd4};
      #1;
      check("samecyc.src", {32'd0, src2[31:0]}, 64'h55);
      check("samecyc.busy", {63'd0, sb2[0]}, 64'd0);
      tick(1);
      alloc_ce = 1'b0;
      #1;
      check("after.busy", {63'd0, sb2[0]}, 64'd1);
      check("after.tag", {60'd0, tag2[3:0]}, 64'd6);
      tick(1);

      // Flush discards renames but keeps the commit value
      for (int r = 1; r <= 3; r++) begin
         idle(); alloc_ce = 1'b1; alloc_rd = 5'(r); alloc_tag = 4'(r);
         tick(1);
      end
      idle(); flush = 1'b1; wb_ce = 1'b1; wr = 5'd2; w_tag = 4'd0; wd = 32'h77;
      alloc_ce = 1'b1; alloc_rd = 5'd9; alloc_tag = 4'd1;
      tick(1);
      idle(); ce2 = 2'b11; rs2 = {5'd2, 5'd1};
      #1;
      check("flush.cnt", {58'd0, cnt2}, 64'd0);
      check("flush.val2", {32'd0, src2[63:32]}, 64'h77);
      check("flush.busy", {62'd0, sb2}, 64'd0);
      tick(1);

      // Register 0 cannot be renamed or written, on every port
      idle(); alloc_ce = 1'b1; alloc_rd = 5'd0; alloc_tag = 4'd5;
      wb_ce = 1'b1; wr = 5'd0; wd = 32'hFF;
      ce2 = 2'b11; rs2 = '0; ce4 = 4'b1111; rs4 = '0;
      #1;
      check("r0.src4.now", src4[127:64], 64'd0);
      tick(1);
      idle(); ce2 = 2'b11; rs2 = '0; ce4 = 4'b1111; rs4 = '0;
      #1;
      check("r0.src2", src2, 64'd0);
      check("r0.src4.lo", src4[63:0], 64'd0);
      check("r0.src4.hi", src4[127:64], 64'd0);
      check("r0.busy4", {60'd0, sb4}, 64'd0);
      check("r0.cnt", {58'd0, cnt4}, 64'd0);
      tick(1);

      // Reset mid-operation drops all renames in one edge
      for (int r = 10; r < 14; r++) begin
         idle(); alloc_ce = 1'b1; alloc_rd = 5'(r); alloc_tag = 4'(r);
         wb_ce = 1'b1; wr = 5'(r + 10); wd = 32'(r * 3);
         tick(1);
      end
      idle(); rst = 1'b1; alloc_ce = 1'b1; alloc_rd = 5'd15; flush = 1'b1;
      tick(1);
      idle(); ce4 = 4'b1111; rs4 = {5'd10, 5'd11, 5'd15, 5'd21};
      #1;
      check("midrst.cnt", {58'd0, cnt4}, 64'd0);
      check("midrst.busy", {60'd0, sb4}, 64'd0);
      check("midrst.src", src4, 128'd0);
      tick(1);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] r;
         idle();
         rst       = ($urandom_range(199, 0) == 0);
         flush     = ($urandom_range(39, 0) == 0);
         alloc_ce  = ($urandom_range(2, 0) != 0);
         alloc_rd  = 5'($urandom_range(9, 0));
         alloc_tag = 4'($urandom);
         wb_ce     = ($urandom_range(1, 0) == 1);
         r         = 5'($urandom_range(9, 0));
         wr        = r;
         w_tag     = ($urandom_range(2, 0) != 0) ? m_tag[r] : 4'($urandom);
         wd        = $urandom;
         ce2       = 2'($urandom);
         ce4       = 4'($urandom);
         for (int p = 0; p < 2; p++) rs2[p*5 +: 5] = 5'($urandom_range(9, 0));
         for (int p = 0; p < 4; p++) rs4[p*5 +: 5] = ($urandom_range(3, 0) == 0) ? wr : 5'($urandom_range(31, 0));
         tick(1);
      end

      idle();
      tick(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
